// File: rtl/gp_regfile_pkg.sv
// ----------------------------------------------------------------------------
// gp_regfile_pkg
//   Shared definitions for the general-purpose register file of the 8-bit
//   crypto processor datapath.
//   - GP_DATA_W / GP_NUM_REGS : default register width and entry count, also
//                               used by the decoder and ALU.
//   - zs_state_e              : zeroize sequencer state (IDLE, CLEAR, DONE).
// ----------------------------------------------------------------------------
package gp_regfile_pkg;

   localparam int GP_DATA_W   = 8;
   localparam int GP_NUM_REGS = 4;

   typedef enum logic [1:0] {
      ZS_IDLE  = 2'd0,
      ZS_CLEAR = 2'd1,
      ZS_DONE  = 2'd2
   } zs_state_e;

endpackage : gp_regfile_pkg

// File: rtl/gp_regfile_zeroize_ctrl.sv
// ----------------------------------------------------------------------------
// gp_regfile_zeroize_ctrl
//   Zeroize sequencer: on a request in IDLE it walks idx from 0 to
//   NUM_REGS-1, asking the storage to clear one entry per cycle, then spends
//   one cycle in DONE before returning to IDLE.
//
//   Ports
//     clk, rst      : clock, synchronous active-high reset
//     zeroize_req   : start request, honoured in IDLE only (never queued)
//     clr_en        : clear entry clr_idx at the coming edge
//     clr_idx       : entry to clear
//     busy          : sequence in CLEAR or DONE
//     zeroize_done  : high for the single DONE cycle
// ----------------------------------------------------------------------------
module gp_regfile_zeroize_ctrl
   import gp_regfile_pkg::*;
#(
   parameter  int NUM_REGS = GP_NUM_REGS,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              zeroize_req,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_idx,
   output logic              busy,
   output logic              zeroize_done
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   zs_state_e         state_q, state_d;
   logic [ADDR_W-1:0] idx_q,   idx_d;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ZS_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: every output of this block gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      clr_en  = 1'b0;
      unique case (state_q)
         ZS_IDLE: begin
            if (zeroize_req) begin
               state_d = ZS_CLEAR;
               idx_d   = '0;
            end
         end
         ZS_CLEAR: begin
            clr_en = 1'b1;
            // idx stops on the last entry instead of wrapping; it is
            // re-initialised on the next start.
            if (idx_q == LAST_IDX) begin
               state_d = ZS_DONE;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         ZS_DONE: begin
            state_d = ZS_IDLE;
         end
         default: begin
            state_d = ZS_IDLE;
         end
      endcase
   end

   assign clr_idx      = idx_q;
   assign busy         = (state_q != ZS_IDLE);
   assign zeroize_done = (state_q == ZS_DONE);

endmodule : gp_regfile_zeroize_ctrl

// File: rtl/gp_regfile.sv
// ----------------------------------------------------------------------------
// gp_regfile
//   NUM_REGS x DATA_W register file, one write port and two combinational
//   read ports, with optional write-to-read bypass, optional hard-wired zero
//   entry 0 and a one-entry-per-cycle zeroize sequence for key scrubbing.
//
//   Ports
//     clk, rst          : clock, synchronous active-high reset
//     we, waddr, wdata  : write port (from the instruction decoder)
//     raddr_a, rdata_a  : read port A (combinational)
//     raddr_b, rdata_b  : read port B (combinational)
//     zeroize_req       : start scrubbing all entries (IDLE only)
//     busy              : zeroize in progress; reads return 0, writes drop
//     zeroize_done      : one-cycle pulse at the end of the sequence
//     wr_drop           : registered pulse, a write arrived while busy
// ----------------------------------------------------------------------------
module gp_regfile
   import gp_regfile_pkg::*;
#(
   parameter  int DATA_W    = GP_DATA_W,
   parameter  int NUM_REGS  = GP_NUM_REGS,
   parameter  int BYPASS    = 1,
   parameter  int ZERO_REG0 = 0,
   localparam int ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              zeroize_req,
   output logic              busy,
   output logic              zeroize_done,
   output logic              wr_drop
);

   // One extra bit so NUM_REGS itself is representable (e.g. 256 entries).
   localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

   // An address names real, writable storage: inside the array and not the
   // hard-wired zero entry.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < NUM_REGS_W) && !((ZERO_REG0 != 0) && (a == '0));
   endfunction

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              wr_drop_q, wr_drop_d;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_idx;
   logic              wr_ok;

   gp_regfile_zeroize_ctrl #(
      .NUM_REGS (NUM_REGS)
   ) u_zeroize_ctrl (
      .clk          (clk),
      .rst          (rst),
      .zeroize_req  (zeroize_req),
      .clr_en       (clr_en),
      .clr_idx      (clr_idx),
      .busy         (busy),
      .zeroize_done (zeroize_done)
   );

   // Writes are refused while scrubbing; out-of-range and zero-entry writes
   // vanish silently (no wr_drop).
   assign wr_ok     = we && !busy && !rst && addr_live(waddr);
   assign wr_drop_d = we && busy;

   // Clear and write never coincide: clearing happens only while busy,
   // writes only while idle.
   always_comb begin
      regs_d = regs_q;
      if (clr_en) begin
         regs_d[clr_idx] = '0;
      end else if (wr_ok) begin
         regs_d[waddr] = wdata;
      end
   end

   // NOTE: the storage array is reset explicitly; reset doubles as an
   // immediate key wipe, so stale contents must never survive it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         wr_drop_q <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   // Reads are blanked while busy so a half-scrubbed array never leaks.
   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      if (!busy && addr_live(raddr_a)) begin
         if ((BYPASS != 0) && wr_ok && (waddr == raddr_a)) begin
            rdata_a = wdata;
         end else begin
            rdata_a = regs_q[raddr_a];
         end
      end
      if (!busy && addr_live(raddr_b)) begin
         if ((BYPASS != 0) && wr_ok && (waddr == raddr_b)) begin
            rdata_b = wdata;
         end else begin
            rdata_b = regs_q[raddr_b];
         end
      end
   end

   assign wr_drop = wr_drop_q;

endmodule : gp_regfile

// File: tb/tb_gp_regfile.sv
// ----------------------------------------------------------------------------
// tb_gp_regfile
//   Three register files share one stimulus stream:
//     [0] BYPASS=1, NUM_REGS=4, ZERO_REG0=0
//     [1] BYPASS=0, NUM_REGS=4, ZERO_REG0=0
//     [2] BYPASS=1, NUM_REGS=3, ZERO_REG0=1
//   A behavioural model (array contents plus a zeroize cycle counter) is
//   checked against every output on each falling edge; directed literal
//   checks pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_gp_regfile;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int NI = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          we = 1'b0;
   logic          zeroize_req = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [AW-1:0] raddr_a = '0;
   logic [AW-1:0] raddr_b = '0;
   logic [DW-1:0] wdata = '0;

   logic [DW-1:0] rd_a   [NI];
   logic [DW-1:0] rd_b   [NI];
   logic          busy_o [NI];
   logic          done_o [NI];
   logic          drop_o [NI];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   gp_regfile #(.DATA_W(DW), .NUM_REGS(4), .BYPASS(1), .ZERO_REG0(0)) u_byp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[0]), .rdata_b(rd_b[0]),
      .zeroize_req(zeroize_req), .busy(busy_o[0]), .zeroize_done(done_o[0]),
      .wr_drop(drop_o[0]));

   gp_regfile #(.DATA_W(DW), .NUM_REGS(4), .BYPASS(0), .ZERO_REG0(0)) u_nobyp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[1]), .rdata_b(rd_b[1]),
      .zeroize_req(zeroize_req), .busy(busy_o[1]), .zeroize_done(done_o[1]),
      .wr_drop(drop_o[1]));

   gp_regfile #(.DATA_W(DW), .NUM_REGS(3), .BYPASS(1), .ZERO_REG0(1)) u_z0 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rd_a[2]), .rdata_b(rd_b[2]),
      .zeroize_req(zeroize_req), .busy(busy_o[2]), .zeroize_done(done_o[2]),
      .wr_drop(drop_o[2]));

   // ---------------------------------------------------------------- checking
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------- model
   int cfg_n   [NI] = '{4, 4, 3};
   bit cfg_byp [NI] = '{1'b1, 1'b0, 1'b1};
   bit cfg_z0  [NI] = '{1'b0, 1'b0, 1'b1};

   logic [DW-1:0] m_regs   [NI][4];
   bit            m_active [NI];   // zeroize in progress
   int            m_zc     [NI];   // edges since the request was taken
   bit            m_drop   [NI];
   bit            model_live = 1'b0;

   function automatic bit m_wr_ok(input int k);
      return we && !rst && !m_active[k] && (int'(waddr) < cfg_n[k]) &&
             !(cfg_z0[k] && waddr == '0);
   endfunction

   function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] ra);
      if (m_active[k]) return '0;
      if (int'(ra) >= cfg_n[k]) return '0;
      if (cfg_z0[k] && ra == '0) return '0;
      if (cfg_byp[k] && m_wr_ok(k) && waddr == ra) return wdata;
      return m_regs[k][ra];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         model_live = 1'b1;
         for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 4; i++) m_regs[k][i] = '0;
            m_active[k] = 1'b0;
            m_zc[k]     = 0;
            m_drop[k]   = 1'b0;
         end
      end else begin
         for (int k = 0; k < NI; k++) begin
            bit ok;
            ok        = m_wr_ok(k);
            m_drop[k] = we && m_active[k];
            if (m_active[k]) begin
               // Edge i after the request clears entry i-1; one more edge
               // after the last clear ends the sequence.
               if (m_zc[k] < cfg_n[k]) m_regs[k][m_zc[k]] = '0;
               m_zc[k]++;
               if (m_zc[k] > cfg_n[k]) m_active[k] = 1'b0;
            end else begin
               if (ok) m_regs[k][waddr] = wdata;
               if (zeroize_req) begin
                  m_active[k] = 1'b1;
                  m_zc[k]     = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         for (int k = 0; k < NI; k++) begin
            check($sformatf("rdata_a[%0d]", k), 32'(rd_a[k]), 32'(exp_rd(k, raddr_a)));
            check($sformatf("rdata_b[%0d]", k), 32'(rd_b[k]), 32'(exp_rd(k, raddr_b)));
            check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(m_active[k]));
            check($sformatf("zeroize_done[%0d]", k), 32'(done_o[k]),
                  32'(m_active[k] && m_zc[k] == cfg_n[k]));
            check($sformatf("wr_drop[%0d]", k), 32'(drop_o[k]), 32'(m_drop[k]));
         end
      end
   end

   // --------------------------------------------------------------- stimulus
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      we    = 1'b1;
      waddr = AW'(a);
      wdata = DW'(d);
      cyc();
      we    = 1'b0;
   endtask

   task automatic load4(input int d0, input int d1, input int d2, input int d3);
      wr(0, d0); wr(1, d1); wr(2, d2); wr(3, d3);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy_o[0] || busy_o[1] || busy_o[2]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle timeout", 32'(n >= budget), 32'd0);
   endtask

   typedef struct { int wa; int wd; int ra; int rb; } vec_t;
   vec_t tbl [6] = '{
      '{1, 8'h3E, 1, 2}, '{2, 8'hC1, 1, 2}, '{3, 8'h7F, 3, 0},
      '{0, 8'h55, 0, 3}, '{1, 8'h00, 1, 1}, '{2, 8'hA5, 3, 2}
   };

   initial begin
      int nb, nd, done_at;

      // Reset
      repeat (2) cyc();
      rst = 1'b0;
      @(negedge clk);
      check("reset rdata_a", 32'(rd_a[0]), 32'h00);
      check("reset busy",    32'(busy_o[0]), 32'd0);
      check("reset wr_drop", 32'(drop_o[0]), 32'd0);
      cyc();

      // Basic write / read
      wr(0, 8'hAA); wr(1, 8'hCC); wr(2, 8'hF0);
      raddr_a = 2'd0; raddr_b = 2'd1;
      @(negedge clk);
      check("read 0",          32'(rd_a[0]), 32'hAA);
      check("read 1",          32'(rd_b[0]), 32'hCC);
      check("zero reg read 0", 32'(rd_a[2]), 32'h00);
      check("z0 read 1",       32'(rd_b[2]), 32'hCC);
      raddr_a = 2'd2;
      #1;
      check("read 2", 32'(rd_a[0]), 32'hF0);
      cyc();

      // Bypass vs no bypass
      we = 1'b1; waddr = 2'd3; wdata = 8'h5A; raddr_a = 2'd3;
      @(negedge clk);
      check("bypass pre-edge",    32'(rd_a[0]), 32'h5A);
      check("no bypass pre-edge", 32'(rd_a[1]), 32'h00);
      check("oob write read",     32'(rd_a[2]), 32'h00);
      cyc();
      we = 1'b0;
      @(negedge clk);
      check("no bypass post-edge", 32'(rd_a[1]), 32'h5A);
      cyc();

      // Zeroize
      load4(8'h11, 8'h22, 8'h33, 8'h44);
      raddr_a = 2'd1; raddr_b = 2'd2;
      zeroize_req = 1'b1;
      cyc();
      zeroize_req = 1'b0;
      nb = 0; nd = 0; done_at = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy_o[0]) break;
         nb++;
         if (done_o[0]) begin
            nd++;
            done_at = nb;
         end
      end
      check("zeroize busy cycles",  32'(nb), 32'd5);
      check("zeroize done pulses",  32'(nd), 32'd1);
      check("zeroize done at last", 32'(done_at), 32'd5);
      for (int a = 0; a < 4; a++) begin
         raddr_a = AW'(a);
         #1;
         check($sformatf("scrubbed entry %0d", a), 32'(rd_a[0]), 32'h00);
      end
      cyc();

      // Write during busy; second request while busy is ignored
      load4(8'h11, 8'h22, 8'h33, 8'h44);
      zeroize_req = 1'b1;
      cyc();                 // request taken
      cyc();                 // re-request in 1st CLEAR cycle
      zeroize_req = 1'b0;
      we = 1'b1; waddr = 2'd1; wdata = 8'h77;
      cyc();
      we = 1'b0;
      @(negedge clk);
      check("wr_drop pulse", 32'(drop_o[0]), 32'd1);
      wait_idle(20);
      raddr_a = 2'd1;
      cyc();
      @(negedge clk);
      check("dropped write entry 1", 32'(rd_a[0]), 32'h00);
      check("request not queued",    32'(busy_o[0]), 32'd0);
      cyc();

      // Reset mid-sequence
      load4(8'h11, 8'h22, 8'h33, 8'h44);
      zeroize_req = 1'b1;
      cyc();
      zeroize_req = 1'b0;
      cyc();                 // now 2nd CLEAR cycle
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("abort busy", 32'(busy_o[0]), 32'd0);
      nd = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_o[0] || done_o[1] || done_o[2]) nd++;
      end
      check("abort no done", 32'(nd), 32'd0);
      for (int a = 0; a < 4; a++) begin
         raddr_b = AW'(a);
         #1;
         check($sformatf("abort entry %0d", a), 32'(rd_b[0]), 32'h00);
      end
      cyc();

      // Mixed directed writes/reads
      foreach (tbl[i]) begin
         we = 1'b1;
         waddr = AW'(tbl[i].wa); wdata = DW'(tbl[i].wd);
         raddr_a = AW'(tbl[i].ra); raddr_b = AW'(tbl[i].rb);
         cyc();
      end
      we = 1'b0;
      cyc();

      // Zero register / out-of-range / write+zeroize
      wr(0, 8'hFF);
      raddr_a = 2'd0;
      @(negedge clk);
      check("z0 write 0 reads 0", 32'(rd_a[2]), 32'h00);
      check("write 0 reads FF",   32'(rd_a[0]), 32'hFF);
      cyc();
      wr(3, 8'h3C);
      @(negedge clk);
      check("oob no wr_drop", 32'(drop_o[2]), 32'd0);
      raddr_a = 2'd3;
      #1;
      check("oob read 3",    32'(rd_a[2]), 32'h00);
      check("read 3 is 3C",  32'(rd_a[0]), 32'h3C);
      cyc();
      we = 1'b1; waddr = 2'd1; wdata = 8'h9C; zeroize_req = 1'b1; raddr_b = 2'd1;
      @(negedge clk);
      check("write+zeroize bypass", 32'(rd_b[2]), 32'h9C);
      cyc();
      we = 1'b0; zeroize_req = 1'b0;
      wait_idle(20);
      #1;
      check("write+zeroize z0 entry 1",  32'(rd_b[2]), 32'h00);
      check("write+zeroize byp entry 1", 32'(rd_b[0]), 32'h00);
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule : tb_gp_regfile
